// File: rtl/motor_driver_axil_slave.sv
// -----------------------------------------------------------------------------
// motor_driver_axil_slave
//
// AXI4-Lite register slave for the MotorDriver IP. It holds four 32-bit
// read/write registers and drives an on-block PWM generator from them.
//
//   0x0 CTRL    [0] enable, [1] dir, [2] brake (all 32 bits stored/readable)
//   0x4 PERIOD  PWM period in clock cycles
//   0x8 DUTY    PWM high time in clock cycles
//   0xC SCRATCH free storage
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESETN  clock (rising edge) and synchronous active-low reset
//   S_AXI_AW*                  write address channel (AWPROT ignored)
//   S_AXI_W*                   write data channel, WSTRB bit n gates byte n
//   S_AXI_B*                   write response channel, BRESP always OKAY
//   S_AXI_AR*                  read address channel (ARPROT ignored)
//   S_AXI_R*                   read data channel, RRESP always OKAY
//   pwm_out                    registered PWM output to the motor bridge
//   dir_out, brake_out         registered copies of CTRL[1] / CTRL[2]
//
// Handshake rules (all channels): a transfer happens on a rising edge where
// VALID and READY are both high. VALID, once raised by the sender, is held
// with stable payload until that edge. READY here is a single-cycle pulse that
// only rises alongside VALID, so each accepted beat produces exactly one pulse.
// -----------------------------------------------------------------------------
module motor_driver_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            pwm_out,
  output logic                            dir_out,
  output logic                            brake_out
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [DW-1:0] ONE = DW'(1);

  // Register file: index 0 CTRL, 1 PERIOD, 2 DUTY, 3 SCRATCH
  logic [DW-1:0] regs [4];

  // Write channel state
  logic          aw_held;
  logic [1:0]    aw_idx_q;
  logic          w_held;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;
  logic          bvalid_q;
  logic          aw_ready;
  logic          w_ready;
  logic          commit;

  // Read channel state
  logic          ar_ready;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  // PWM state
  logic [DW-1:0] cnt;
  logic [DW-1:0] period_s;
  logic [DW-1:0] duty_s;
  logic          pwm_q;
  logic          dir_q;
  logic          brake_q;

  // Word-aligned access: the byte-offset bits and protection bits carry no meaning
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ---------------------------------------------------------------------------
  // Write path. Address and data are captured independently; the register is
  // written one edge after both are held, which is also the edge BVALID rises.
  // Gating READY with ARESETN keeps it low while reset is asserted.
  // ---------------------------------------------------------------------------
  assign aw_ready = S_AXI_ARESETN & S_AXI_AWVALID & ~aw_held & ~bvalid_q;
  assign w_ready  = S_AXI_ARESETN & S_AXI_WVALID  & ~w_held  & ~bvalid_q;
  assign commit   = aw_held & w_held;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      aw_held  <= 1'b0;
      aw_idx_q <= '0;
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid_q <= 1'b0;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_ready) begin
          aw_held  <= 1'b1;
          aw_idx_q <= S_AXI_AWADDR[3:2];
        end
        if (w_ready) begin
          w_held   <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
      end

      if (commit) begin
        bvalid_q <= 1'b1;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      for (int b = 0; b < SW; b++) begin
        if (w_strb_q[b]) begin
          regs[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
        end
      end
    end
  end

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = w_ready;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;

  // ---------------------------------------------------------------------------
  // Read path. RDATA is captured on the address handshake edge; because the
  // register file updates with non-blocking assignment on the same edge, a
  // read that coincides with a write commit returns the pre-write value.
  // ---------------------------------------------------------------------------
  assign ar_ready = S_AXI_ARESETN & S_AXI_ARVALID & ~rvalid_q;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (ar_ready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= regs[S_AXI_ARADDR[3:2]];
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

  // ---------------------------------------------------------------------------
  // PWM generator. PERIOD/DUTY are copied into shadows only at a period
  // boundary (or continuously while disabled) so a register write never
  // distorts the period in progress. A zero shadow period is treated as a
  // boundary every cycle, so a later non-zero PERIOD is still picked up.
  // ---------------------------------------------------------------------------
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      cnt      <= '0;
      period_s <= '0;
      duty_s   <= '0;
      pwm_q    <= 1'b0;
      dir_q    <= 1'b0;
      brake_q  <= 1'b0;
    end else begin
      dir_q   <= regs[0][1];
      brake_q <= regs[0][2];
      if (!regs[0][0]) begin
        cnt      <= '0;
        period_s <= regs[1];
        duty_s   <= regs[2];
        pwm_q    <= 1'b0;
      end else begin
        pwm_q <= ~regs[0][2] & (period_s != '0) & (cnt < duty_s);
        if ((period_s == '0) || (cnt == period_s - ONE)) begin
          cnt      <= '0;
          period_s <= regs[1];
          duty_s   <= regs[2];
        end else begin
          cnt <= cnt + ONE;
        end
      end
    end
  end

  assign pwm_out   = pwm_q;
  assign dir_out   = dir_q;
  assign brake_out = brake_q;

endmodule

// File: tb/tb_motor_driver_axil_slave.sv
// -----------------------------------------------------------------------------
// tb_motor_driver_axil_slave
//
// Directed bench for motor_driver_axil_slave: a register access table, a PWM
// setting table, and hand-written sequences for split AW/W timing, response
// back-pressure, read/write collision, mid-period duty change and reset.
// -----------------------------------------------------------------------------
module tb_motor_driver_axil_slave;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic arst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        pwm_out;
  logic        dir_out;
  logic        brake_out;

  motor_driver_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(arst_n),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .pwm_out      (pwm_out),
    .dir_out      (dir_out),
    .brake_out    (brake_out)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // ---------------------------------------------------------------------------
  int n_total;
  int n_pass;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks. Inputs change 1ns after a rising edge; outputs are read
  // after a further settle delay, never on the edge itself.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic ok);
    logic a_done, w_done, b_done, a_hs, w_hs;
    a_done = 1'b0; w_done = 1'b0; b_done = 1'b0; resp = 2'b11;
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    bready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      a_hs = awvalid & awready;
      w_hs = wvalid & wready;
      step();
      if (a_hs) begin awvalid = 1'b0; a_done = 1'b1; end
      if (w_hs) begin wvalid = 1'b0; w_done = 1'b1; end
      if (a_done && w_done) break;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bvalid) begin
        resp = bresp; b_done = 1'b1;
        step();
        break;
      end
      step();
    end
    bready = 1'b0;
    ok = a_done & w_done & b_done;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output logic ok);
    logic a_done, r_done, a_hs;
    a_done = 1'b0; r_done = 1'b0; data = '0; resp = 2'b11;
    araddr = addr; arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      a_hs = arvalid & arready;
      step();
      if (a_hs) begin a_done = 1'b1; break; end
    end
    arvalid = 1'b0;
    rready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rvalid) begin
        data = rdata; resp = rresp; r_done = 1'b1;
        step();
        break;
      end
      step();
    end
    rready = 1'b0;
    ok = a_done & r_done;
  endtask

  task automatic wr(input string name, input logic [3:0] addr, input logic [31:0] data);
    logic [1:0] resp;
    logic ok;
    axi_write(addr, data, 4'hF, resp, ok);
    chk({name, "_handshake"}, 32'(ok), 32'd1);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0] resp;
    logic ok;
    axi_read(addr, d, resp, ok);
    chk({name, "_handshake"}, 32'(ok), 32'd1);
    chk({name, "_rdata"}, d, exp);
    chk({name, "_rresp"}, 32'(resp), 32'd0);
  endtask

  // Counts cycles with pwm_out high over n samples
  task automatic count_high(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      if (pwm_out) highs++;
      step();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector tables
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;   // expected read data (reads) / unused (writes)
  } vec_t;

  typedef struct {
    logic [31:0] period;
    logic [31:0] duty;
    int          highs; // expected high cycles in a 20-cycle window
  } pwm_vec_t;

  vec_t     vecs[$];
  pwm_vec_t pvecs[$];

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  resp;
    logic        ok, bad, seen_high;
    logic        smp [30];
    logic        prev, found;
    int          highs, h0, h1;

    n_total = 0; n_pass = 0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

    vecs.push_back('{1'b1, 4'h0, 32'd1,         4'hF, 32'd0});
    vecs.push_back('{1'b1, 4'h4, 32'd2,         4'hF, 32'd0});
    vecs.push_back('{1'b1, 4'h8, 32'd3,         4'hF, 32'd0});
    vecs.push_back('{1'b1, 4'hC, 32'd4,         4'hF, 32'd0});
    vecs.push_back('{1'b0, 4'h0, 32'd0,         4'h0, 32'd1});
    vecs.push_back('{1'b0, 4'h4, 32'd0,         4'h0, 32'd2});
    vecs.push_back('{1'b0, 4'h8, 32'd0,         4'h0, 32'd3});
    vecs.push_back('{1'b0, 4'hC, 32'd0,         4'h0, 32'd4});
    vecs.push_back('{1'b1, 4'hC, 32'd0,         4'hF, 32'd0});
    vecs.push_back('{1'b1, 4'hC, 32'hFFFFFFFF,  4'b0010, 32'd0});
    vecs.push_back('{1'b0, 4'hC, 32'd0,         4'h0, 32'h0000FF00});
    vecs.push_back('{1'b1, 4'hE, 32'hDEADBEEF,  4'hF, 32'd0});
    vecs.push_back('{1'b0, 4'hD, 32'd0,         4'h0, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 4'hC, 32'hFFFFFFFF,  4'b0101, 32'd0});
    vecs.push_back('{1'b0, 4'hC, 32'd0,         4'h0, 32'hDEFFBEFF});
    vecs.push_back('{1'b1, 4'hC, 32'h12345678,  4'b0000, 32'd0});
    vecs.push_back('{1'b0, 4'hC, 32'd0,         4'h0, 32'hDEFFBEFF});
    vecs.push_back('{1'b1, 4'h0, 32'd0,         4'hF, 32'd0});
    vecs.push_back('{1'b0, 4'h3, 32'd0,         4'h0, 32'd0});

    pvecs.push_back('{32'd10, 32'd12, 20});
    pvecs.push_back('{32'd10, 32'd0,  0});
    pvecs.push_back('{32'd0,  32'd5,  0});
    pvecs.push_back('{32'd4,  32'd1,  5});
    pvecs.push_back('{32'd10, 32'd3,  6});

    // Reset
    arst_n = 1'b0;
    repeat (3) step();
    arst_n = 1'b1;
    #1;
    chk("reset_ready", 32'({awready, wready, arready}), 32'd0);
    chk("reset_valid", 32'({bvalid, rvalid}), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_pins", 32'({pwm_out, dir_out, brake_out}), 32'd0);

    // Register access table
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, ok);
        chk($sformatf("vec%0d_wr_handshake", i), 32'(ok), 32'd1);
        chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'd0);
      end else begin
        rd_chk($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp);
      end
    end

    // AW at cycle 0, W at cycle 3: BVALID only after the edge following W
    step();
    awaddr = 4'hC; awvalid = 1'b1;
    #1;
    chk("split_awready", 32'(awready), 32'd1);
    step();
    awvalid = 1'b0;
    bad = 1'b0;
    repeat (2) begin
      #1;
      if (bvalid || wready) bad = 1'b1;
      step();
    end
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    #1;
    chk("split_wready", 32'(wready), 32'd1);
    if (bvalid) bad = 1'b1;
    step();
    wvalid = 1'b0;
    #1;
    if (bvalid) bad = 1'b1;
    chk("split_bvalid_early", 32'(bad), 32'd0);
    step();
    chk("split_bvalid", 32'(bvalid), 32'd1);

    // BREADY low for 10 cycles: BVALID held, no new address/data accepted
    bad = 1'b0;
    awaddr = 4'h8; awvalid = 1'b1; wdata = 32'h55; wvalid = 1'b1;
    repeat (10) begin
      #1;
      if (!bvalid || awready || wready) bad = 1'b1;
      step();
    end
    chk("bstall_hold", 32'(bad), 32'd0);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    step();
    bready = 1'b0;
    #1;
    chk("bstall_release", 32'(bvalid), 32'd0);
    rd_chk("split_readback", 4'hC, 32'hA5A5A5A5);
    rd_chk("bstall_no_write", 4'h8, 32'd3);

    // RREADY low for 10 cycles: RDATA stable, no second ARREADY
    araddr = 4'h4; arvalid = 1'b1;
    #1;
    chk("rstall_arready", 32'(arready), 32'd1);
    step();
    araddr = 4'h0;
    bad = 1'b0;
    repeat (10) begin
      #1;
      if (!rvalid || rdata !== 32'd2 || arready) bad = 1'b1;
      step();
    end
    chk("rstall_hold", 32'(bad), 32'd0);
    arvalid = 1'b0; rready = 1'b1;
    step();
    rready = 1'b0;
    #1;
    chk("rstall_release", 32'(rvalid), 32'd0);

    // Read of SCRATCH on the same edge its write commits: old value returned
    awaddr = 4'hC; awvalid = 1'b1; wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1;
    #1;
    chk("coll_aw_w_ready", 32'({awready, wready}), 32'd3);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 4'hC; arvalid = 1'b1;
    #1;
    chk("coll_arready", 32'(arready), 32'd1);
    step();
    arvalid = 1'b0;
    #1;
    chk("coll_bvalid", 32'(bvalid), 32'd1);
    chk("coll_rdata_old", rdata, 32'hA5A5A5A5);
    rready = 1'b1; bready = 1'b1;
    step();
    rready = 1'b0; bready = 1'b0;
    rd_chk("coll_readback", 4'hC, 32'h11111111);

    // PWM: PERIOD=10 DUTY=3, then DUTY=7 written just after a period starts
    wr("pwm_period", 4'h4, 32'd10);
    wr("pwm_duty", 4'h8, 32'd3);
    wr("pwm_enable", 4'h0, 32'd1);
    prev = pwm_out; found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pwm_out && !prev) begin found = 1'b1; break; end
      prev = pwm_out;
    end
    chk("pwm_rise_seen", 32'(found), 32'd1);
    smp[0] = pwm_out;
    fork
      begin
        axi_write(4'h8, 32'd7, 4'hF, resp, ok);
      end
      begin
        for (int k = 1; k < 30; k++) begin
          @(negedge clk);
          smp[k] = pwm_out;
        end
      end
    join
    chk("pwm_mid_wr_handshake", 32'(ok), 32'd1);
    h0 = 0; h1 = 0;
    for (int k = 0; k < 10; k++) begin
      if (smp[k]) h0++;
      if (smp[k+10]) h1++;
    end
    chk("pwm_old_period_highs", 32'(h0), 32'd3);
    chk("pwm_old_pattern", 32'({smp[0], smp[1], smp[2], smp[3], smp[9]}), 32'b11100);
    chk("pwm_new_period_highs", 32'(h1), 32'd7);
    chk("pwm_new_pattern", 32'({smp[10], smp[16], smp[17], smp[19], smp[20]}), 32'b11001);

    // PWM settings table: boundary duty/period values
    foreach (pvecs[i]) begin
      wr($sformatf("pvec%0d_period", i), 4'h4, pvecs[i].period);
      wr($sformatf("pvec%0d_duty", i), 4'h8, pvecs[i].duty);
      repeat (25) step();
      count_high(20, highs);
      chk($sformatf("pvec%0d_highs", i), 32'(highs), 32'(pvecs[i].highs));
    end

    // Brake forces pwm low; dir/brake pins follow CTRL
    wr("brake_ctrl", 4'h0, 32'd5);
    repeat (2) step();
    count_high(12, highs);
    chk("brake_pwm_low", 32'(highs), 32'd0);
    chk("brake_pins", 32'({dir_out, brake_out}), 32'b01);
    wr("dir_ctrl", 4'h0, 32'd3);
    wr("dir_duty", 4'h8, 32'd7);
    repeat (2) step();
    chk("dir_pins", 32'({dir_out, brake_out}), 32'b10);
    seen_high = 1'b0;
    repeat (12) begin
      if (pwm_out) seen_high = 1'b1;
      step();
    end
    chk("pwm_active_before_reset", 32'(seen_high), 32'd1);

    // Reset while BVALID is pending and PWM is running
    awaddr = 4'hC; awvalid = 1'b1; wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
    #1;
    chk("rst_aw_w_ready", 32'({awready, wready}), 32'd3);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    chk("rst_bvalid_pending", 32'(bvalid), 32'd1);
    arst_n = 1'b0;
    step();
    arst_n = 1'b1;
    #1;
    chk("rst_valid", 32'({bvalid, rvalid}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_pins", 32'({pwm_out, dir_out, brake_out}), 32'd0);
    for (int r = 0; r < 4; r++) begin
      rd_chk($sformatf("rst_reg%0d", r), 4'(r * 4), 32'd0);
    end
    count_high(12, highs);
    chk("rst_pwm_idle", 32'(highs), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
